clock_mode_ctrl: RTL and testbench

Mode/set controller for the digital clock. Turns two active-low push keys into the run/set sequencing for the minute and hour counters. In RUN it lets the minute counter free-run and passes its hour carry through. In SET_HR and SET_MIN it freezes counting and issues single increment pulses per key press. It sits between the key inputs and the `generateMin`/hour counter chain.

---
 rtl/clock_pkg.sv | 26 ++
 rtl/key_debounce.sv | 65 ++++++
 rtl/clock_mode_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants and types for the digital clock mode/set controller.
package clock_pkg;

  // Mode encoding as seen on the mode output.
  localparam logic [1:0] MODE_RUN     = 2'b00;
  localparam logic [1:0] MODE_SET_HR  = 2'b01;
  localparam logic [1:0] MODE_SET_MIN = 2'b10;

  // Default timing parameters, in clock cycles.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 30;
  localparam int unsigned DEF_BLINK_CYCLES    = 1;
  localparam int unsigned DEF_REPEAT_CYCLES   = 4;

  typedef enum logic [1:0] {
    StRun    = MODE_RUN,
    StSetHr  = MODE_SET_HR,
    StSetMin = MODE_SET_MIN
  } mode_e;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key conditioning: 2-flop synchroniser followed by a level debouncer.
// press is a registered one-cycle pulse on the accepted 1->0 (pressed) edge.
module key_debounce
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_level,
  output logic press
);

  localparam int unsigned     CntW    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Bring the asynchronous key into the clock domain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after enough consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debouncer state; released level after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_level = level_q;
  assign press     = press_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Run/set sequencing for the minute and hour counters, driven by two
// active-low keys. Optional feature macro: AUTO_REPEAT_EN (held inc key
// repeats increments every REPEAT_CYCLES while in a set mode).
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int unsigned BLINK_CYCLES    = DEF_BLINK_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_key,
  input  logic       inc_key,
  input  logic       hr_en_in,
  output logic       count_en,
  output logic       min_inc,
  output logic       hr_inc,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned     TmoW    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam int unsigned     BlkW    = cnt_width(BLINK_CYCLES);
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLINK_CYCLES - 1);

  logic mode_level, mode_press;
  logic inc_level, inc_press;
  logic rep_evt;
  logic inc_evt;
  logic enter_set;
  logic in_set;

  mode_e           state_q, state_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [BlkW-1:0] blk_cnt_q, blk_cnt_d;
  logic            blink_q, blink_d;
  logic            hr_inc_q, hr_inc_d;
  logic            min_inc_q, min_inc_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode_key (
    .clk      (clk),
    .reset    (reset),
    .key_raw  (mode_key),
    .key_level(mode_level),
    .press    (mode_press)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_inc_key (
    .clk      (clk),
    .reset    (reset),
    .key_raw  (inc_key),
    .key_level(inc_level),
    .press    (inc_press)
  );

  assign in_set = (state_q == StSetHr) || (state_q == StSetMin);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned     RepW    = cnt_width(REPEAT_CYCLES);
  localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            unused_mode_level;

  // Restart on each press; fire every REPEAT_CYCLES while the key stays down.
  always_comb begin
    rep_cnt_d = '0;
    rep_evt   = 1'b0;
    if (in_set && !inc_press && !inc_level) begin
      if (rep_cnt_q == RepLast) begin
        rep_evt = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  // Auto-repeat interval counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end

  assign unused_mode_level = mode_level;
`else
  logic [31:0] unused_repeat;
  logic        unused_levels;

  assign rep_evt       = 1'b0;
  assign unused_repeat = REPEAT_CYCLES;
  assign unused_levels = mode_level ^ inc_level;
`endif

  // Mode FSM with timeout and blink; mode key beats inc key, inc beats timeout.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    blink_d   = blink_q;
    blk_cnt_d = blk_cnt_q;
    hr_inc_d  = 1'b0;
    min_inc_d = 1'b0;
    enter_set = 1'b0;
    inc_evt   = inc_press | rep_evt;

    case (state_q)
      StRun: begin
        if (mode_press) begin
          state_d   = StSetHr;
          enter_set = 1'b1;
        end
      end
      StSetHr: begin
        if (mode_press) begin
          state_d   = StSetMin;
          enter_set = 1'b1;
        end else if (inc_evt) begin
          hr_inc_d = 1'b1;
        end else if (tmo_q == TmoLast) begin
          state_d = StRun;
        end
      end
      StSetMin: begin
        if (mode_press) begin
          state_d = StRun;
        end else if (inc_evt) begin
          min_inc_d = 1'b1;
        end else if (tmo_q == TmoLast) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase

    if (state_d == StRun) begin
      tmo_d     = '0;
      blink_d   = 1'b0;
      blk_cnt_d = '0;
    end else if (enter_set) begin
      tmo_d     = '0;
      blink_d   = 1'b1;
      blk_cnt_d = '0;
    end else begin
      if (inc_evt) begin
        tmo_d = '0;
      end else if (tmo_q != TmoLast) begin
        tmo_d = tmo_q + 1'b1;
      end
      if (blk_cnt_q == BlkLast) begin
        blink_d   = ~blink_q;
        blk_cnt_d = '0;
      end else begin
        blk_cnt_d = blk_cnt_q + 1'b1;
      end
    end
  end

  // State, timers and registered increment pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StRun;
      tmo_q     <= '0;
      blink_q   <= 1'b0;
      blk_cnt_q <= '0;
      hr_inc_q  <= 1'b0;
      min_inc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      blink_q   <= blink_d;
      blk_cnt_q <= blk_cnt_d;
      hr_inc_q  <= hr_inc_d;
      min_inc_q <= min_inc_d;
    end
  end

  // Hour carry passes straight through only while running; set modes block it.
  always_comb begin
    count_en = (state_q == StRun);
    hr_inc   = (state_q == StRun) ? hr_en_in : hr_inc_q;
  end

  assign min_inc = min_inc_q;
  assign mode    = state_q;
  assign blink   = blink_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl (default parameters).
module tb_clock_mode_ctrl;
  import clock_pkg::*;

  localparam int unsigned KHr   = 0;
  localparam int unsigned KMin  = 1;
  localparam int unsigned KMode = 2;

  typedef struct {
    int unsigned cyc;
    int unsigned kind;
    int unsigned val;
  } evt_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode_key;
  logic       inc_key;
  logic       hr_en_in;
  logic       count_en;
  logic       min_inc;
  logic       hr_inc;
  logic [1:0] mode;
  logic       blink;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  evt_t        sb_q[$];
  logic        mon_en = 1'b0;
  logic [1:0]  prev_mode = 2'b00;

  clock_mode_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .mode_key(mode_key),
    .inc_key (inc_key),
    .hr_en_in(hr_en_in),
    .count_en(count_en),
    .min_inc (min_inc),
    .hr_inc  (hr_inc),
    .mode    (mode),
    .blink   (blink)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_evt(input int unsigned c, input int unsigned k, input int unsigned v);
    evt_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic observe(input int unsigned k, input int unsigned v);
    evt_t e;
    if (sb_q.size() == 0) begin
      check("sb_unexpected_kind", k, 32'hffff_ffff);
    end else begin
      e = sb_q.pop_front();
      check("sb_kind", k, e.kind);
      check("sb_val", v, e.val);
      check("sb_cycle", cyc, e.cyc);
    end
  endtask

  // Output monitor: every mode change and every set-mode pulse is an event.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mode != prev_mode) observe(KMode, 32'(mode));
      if (hr_inc && (mode != MODE_RUN)) observe(KHr, 1);
      if (min_inc) observe(KMin, 1);
    end
    prev_mode <= mode;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 mode key, 1 inc key, 2 both on the same cycle.
  task automatic press(input int unsigned which, input int unsigned hold, input int unsigned gap);
    if (which != 1) mode_key = 1'b0;
    if (which != 0) inc_key = 1'b0;
    tick(hold);
    mode_key = 1'b1;
    inc_key  = 1'b1;
    tick(gap);
  endtask

  task automatic go_mode(input logic [1:0] m);
    expect_evt(cyc + 5, KMode, 32'(m));
    press(0, 6, 6);
  endtask

  initial begin
    int unsigned k;
    reset    = 1'b0;
    mode_key = 1'b1;
    inc_key  = 1'b1;
    hr_en_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst_mode", 32'(mode), 32'(MODE_RUN));
    check("rst_count_en", 32'(count_en), 1);
    check("rst_min_inc", 32'(min_inc), 0);
    check("rst_hr_inc", 32'(hr_inc), 0);
    check("rst_blink", 32'(blink), 0);
    mon_en = 1'b1;

    hr_en_in = 1'b1;
    #1;
    check("run_carry_hi", 32'(hr_inc), 1);
    hr_en_in = 1'b0;
    #1;
    check("run_carry_lo", 32'(hr_inc), 0);
    tick(2);

    // Mode cycling with boundary timing and blink phase.
    k = cyc;
    expect_evt(k + 5, KMode, 32'(MODE_SET_HR));
    mode_key = 1'b0;
    tick(4);
    check("mode_not_yet", 32'(mode), 32'(MODE_RUN));
    tick(1);
    check("enter_hr_mode", 32'(mode), 32'(MODE_SET_HR));
    check("enter_hr_count_en", 32'(count_en), 0);
    check("enter_hr_blink1", 32'(blink), 1);
    tick(1);
    check("enter_hr_blink0", 32'(blink), 0);
    mode_key = 1'b1;
    tick(6);
    go_mode(MODE_SET_MIN);
    check("set_min_count_en", 32'(count_en), 0);
    go_mode(MODE_RUN);
    check("back_run_count_en", 32'(count_en), 1);
    check("back_run_blink", 32'(blink), 0);

    // Set increments; hour carry blocked in SET_MIN.
    go_mode(MODE_SET_HR);
    expect_evt(cyc + 5, KHr, 1);
    press(1, 6, 6);
    expect_evt(cyc + 5, KHr, 1);
    press(1, 6, 6);
    go_mode(MODE_SET_MIN);
    hr_en_in = 1'b1;
    expect_evt(cyc + 5, KMin, 1);
    press(1, 6, 6);
    check("setmin_no_carry", 32'(hr_inc), 0);
    hr_en_in = 1'b0;
    go_mode(MODE_RUN);

    // Bounce rejection, then one clean press; timeout follows that press.
    go_mode(MODE_SET_HR);
    repeat (5) begin
      inc_key = 1'b0;
      tick(1);
      inc_key = 1'b1;
      tick(1);
    end
    tick(3);
    k = cyc;
    expect_evt(k + 5, KHr, 1);
    expect_evt(k + 35, KMode, 32'(MODE_RUN));
    press(1, 5, 6);
    tick(25);
    check("bounce_tmo_mode", 32'(mode), 32'(MODE_RUN));

    // Clean idle timeout: 30 cycles in SET_HR.
    k = cyc;
    go_mode(MODE_SET_HR);
    expect_evt(k + 35, KMode, 32'(MODE_RUN));
    tick(22);
    check("tmo_not_yet", 32'(mode), 32'(MODE_SET_HR));
    tick(1);
    check("tmo_mode", 32'(mode), 32'(MODE_RUN));
    check("tmo_blink", 32'(blink), 0);
    check("tmo_count_en", 32'(count_en), 1);
    tick(2);

    // Simultaneous keys: mode wins, inc dropped.
    go_mode(MODE_SET_HR);
    expect_evt(cyc + 5, KMode, 32'(MODE_SET_MIN));
    press(2, 6, 6);
    check("simul_mode", 32'(mode), 32'(MODE_SET_MIN));

    // Held inc key in SET_MIN.
    k = cyc;
    expect_evt(k + 5, KMin, 1);
`ifdef AUTO_REPEAT_EN
    for (int i = 1; i <= 4; i++) expect_evt(k + 5 + 4 * i, KMin, 1);
`endif
    press(1, 20, 6);
    go_mode(MODE_RUN);

    // Reset during a set mode cancels the pending pulse.
    go_mode(MODE_SET_HR);
    k = cyc;
    inc_key = 1'b0;
    tick(4);
    reset = 1'b0;
    expect_evt(k + 5, KMode, 32'(MODE_RUN));
    tick(1);
    reset = 1'b1;
    check("midrst_mode", 32'(mode), 32'(MODE_RUN));
    check("midrst_count_en", 32'(count_en), 1);
    check("midrst_blink", 32'(blink), 0);
    check("midrst_hr_inc", 32'(hr_inc), 0);
    tick(1);
    check("midrst_min_inc", 32'(min_inc), 0);
    tick(1);
    inc_key = 1'b1;
    tick(10);

    check("sb_drain", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
